vram_arbiter: RTL and testbench

- Shares the single-port 64K x 8 video SRAM between two requesters: the video scan-out fetcher (read-only) and the CPU bus bridge (read/write).
- Grants at most one access per clock, drives the SRAM address, data and write-enable, and returns tagged read data one cycle later.
- Video has fixed priority. An optional fairness counter bounds CPU wait time.

---
 rtl/vram_arbiter.sv | 72 +++++++
 tb/tb_vram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: video/CPU arbiter for a single-port 64Kx8 SRAM; optional CPU fairness via VRAM_ARB_FAIRNESS_EN
module vram_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_ack,
  output logic        vid_rvalid,
  output logic [7:0]  vid_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] sram_addr,
  output logic [7:0]  sram_wdata,
  output logic        sram_we,
  input  logic [7:0]  sram_rdata
);
  typedef enum logic [1:0] {RD_NONE, RD_VID, RD_CPU} rd_owner_t;
  rd_owner_t   rd_owner_q, rd_owner_d;
  logic [15:0] addr_q, addr_d;
  logic        force_cpu, vid_win, cpu_win;
`ifdef VRAM_ARB_FAIRNESS_EN
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic [3:0] wait_cnt_q, wait_cnt_d;
  // count cycles a pending CPU request loses, saturating at MAX_WAIT
  always_comb begin
    wait_cnt_d = (!cpu_req || cpu_ack) ? 4'd0 : (wait_cnt_q == MW) ? MW : wait_cnt_q + 4'd1;
  end
  // wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= 4'd0;
    else        wait_cnt_q <= wait_cnt_d;
  end
  assign force_cpu = (wait_cnt_q == MW);
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT == 0);
  assign force_cpu = 1'b0;
`endif
  // pick one winner per cycle and steer the SRAM; nothing is granted while in reset
  always_comb begin
    vid_win    = rst_n && vid_req && !(force_cpu && cpu_req);
    cpu_win    = rst_n && cpu_req && !vid_win;
    vid_ack    = vid_win;
    cpu_ack    = cpu_win;
    sram_addr  = vid_win ? vid_addr : cpu_win ? cpu_addr : addr_q;
    sram_we    = cpu_win && cpu_we;
    sram_wdata = cpu_win ? cpu_wdata : 8'h00;
    addr_d     = sram_addr;
    rd_owner_d = vid_win ? RD_VID : (cpu_win && !cpu_we) ? RD_CPU : RD_NONE;
  end
  // read owner and held address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q <= RD_NONE;
      addr_q     <= 16'h0000;
    end else begin
      rd_owner_q <= rd_owner_d;
      addr_q     <= addr_d;
    end
  end
  assign vid_rvalid = (rd_owner_q == RD_VID);
  assign cpu_rvalid = (rd_owner_q == RD_CPU);
  assign vid_rdata  = sram_rdata;
  assign cpu_rdata  = sram_rdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural 64Kx8 SRAM
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vid_req = 1'b0;
  logic [15:0] vid_addr = 16'h0;
  logic        vid_ack, vid_rvalid;
  logic [7:0]  vid_rdata;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic [7:0]  cpu_wdata = 8'h0;
  logic        cpu_ack, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic        sram_we;
  logic [7:0]  sram_rdata = 8'h0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [7:0]  smem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  typedef struct {int stamp; logic [7:0] data;} exp_t;
  exp_t        vq[$];
  exp_t        cq[$];
  exp_t        e;

  vram_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write, read data one cycle after address
  always @(posedge clk) begin
    if (sram_we) smem[sram_addr] <= sram_wdata;
    sram_rdata <= smem[sram_addr];
    cyc <= cyc + 1;
  end

  // scoreboard: pop/compare read returns, then push expectations for this cycle's grants
  always @(negedge clk) begin
    if (!rst_n) begin
      vq.delete();
      cq.delete();
      n_checks++;
      if (vid_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rvalid_in_reset: vid=%b cpu=%b required 0 0", vid_rvalid, cpu_rvalid);
      end
    end else begin
      if (vid_rvalid) begin
        n_checks++;
        if (vq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_vid_unexpected: vid_rvalid=1 with nothing outstanding, data=%h", vid_rdata);
        end else begin
          e = vq.pop_front();
          if (e.stamp != cyc - 1 || vid_rdata !== e.data) begin
            n_fail++;
            $display("FAIL sb_vid_data: got %h at cycle %0d, required %h at cycle %0d", vid_rdata, cyc, e.data, e.stamp + 1);
          end
        end
      end else if (vq.size() > 0) begin
        n_checks++;
        n_fail++;
        e = vq.pop_front();
        $display("FAIL sb_vid_missing: vid_rvalid=0, required 1 with data %h", e.data);
      end
      if (cpu_rvalid) begin
        n_checks++;
        if (cq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_cpu_unexpected: cpu_rvalid=1 with nothing outstanding, data=%h", cpu_rdata);
        end else begin
          e = cq.pop_front();
          if (e.stamp != cyc - 1 || cpu_rdata !== e.data) begin
            n_fail++;
            $display("FAIL sb_cpu_data: got %h at cycle %0d, required %h at cycle %0d", cpu_rdata, cyc, e.data, e.stamp + 1);
          end
        end
      end else if (cq.size() > 0) begin
        n_checks++;
        n_fail++;
        e = cq.pop_front();
        $display("FAIL sb_cpu_missing: cpu_rvalid=0, required 1 with data %h", e.data);
      end
      if (vid_ack) vq.push_back('{cyc, ref_mem[vid_addr]});
      if (cpu_ack && !cpu_we) cq.push_back('{cyc, ref_mem[cpu_addr]});
      if (cpu_ack && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
    end
    n_checks++;
    if (sram_we && !(cpu_ack && cpu_we)) begin
      n_fail++;
      $display("FAIL we_guard: sram_we=1 with cpu_ack=%b cpu_we=%b", cpu_ack, cpu_we);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] va, input logic c, input logic we, input logic [15:0] ca, input logic [7:0] wd);
    vid_req = v; vid_addr = va; cpu_req = c; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
  endtask

  task automatic test_reset();
    drive(1'b1, 16'h0003, 1'b1, 1'b1, 16'h1111, 8'h55);
    repeat (2) step();
    @(negedge clk);
    n_checks++;
    if (vid_ack !== 1'b0 || cpu_ack !== 1'b0 || sram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_acks: vid_ack=%b cpu_ack=%b sram_we=%b required 0 0 0", vid_ack, cpu_ack, sram_we);
    end
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sram_addr !== 16'h0000 || sram_we !== 1'b0 || sram_wdata !== 8'h00 || vid_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: addr=%h we=%b wdata=%h vrv=%b crv=%b required 0000 0 00 0 0", sram_addr, sram_we, sram_wdata, vid_rvalid, cpu_rvalid);
    end
    step();
  endtask

  task automatic test_cpu_rw();
    drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h8001, 8'hA5);
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 16'h8001 || sram_wdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL cpu_write: ack=%b we=%b addr=%h wdata=%h required 1 1 8001 a5", cpu_ack, sram_we, sram_addr, sram_wdata);
    end
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h8001, 8'h00);
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b1 || sram_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_ack: ack=%b we=%b rvalid=%b required 1 0 0", cpu_ack, sram_we, cpu_rvalid);
    end
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA5 || sram_addr !== 16'h8001 || sram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_read_data: rvalid=%b data=%h held_addr=%h we=%b required 1 a5 8001 0", cpu_rvalid, cpu_rdata, sram_addr, sram_we);
    end
    step();
  endtask

  task automatic test_video_burst();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b1, 16'(i), 1'b0, 1'b0, 16'h0, 8'h0);
      else drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
      @(negedge clk);
      n_checks++;
      if (vid_ack !== (i < 4) || vid_rvalid !== (i >= 1 && i <= 4) || (vid_rvalid && vid_rdata !== 8'(8'h0F + i))) begin
        n_fail++;
        $display("FAIL vid_burst[%0d]: ack=%b rvalid=%b data=%h required %b %b %h", i, vid_ack, vid_rvalid, vid_rdata, i < 4, i >= 1 && i <= 4, 8'(8'h0F + i));
      end
      step();
    end
  endtask

  task automatic test_contention();
    drive(1'b1, 16'h0002, 1'b1, 1'b0, 16'h1234, 8'h00);
    @(negedge clk);
    n_checks++;
    if (vid_ack !== 1'b1 || cpu_ack !== 1'b0 || sram_addr !== 16'h0002) begin
      n_fail++;
      $display("FAIL contend_first: vid_ack=%b cpu_ack=%b addr=%h required 1 0 0002", vid_ack, cpu_ack, sram_addr);
    end
    step();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h1234, 8'h00);
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b1 || vid_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || vid_rdata !== 8'h12 || sram_addr !== 16'h1234) begin
      n_fail++;
      $display("FAIL contend_second: cpu_ack=%b vrv=%b crv=%b vdata=%h addr=%h required 1 1 0 12 1234", cpu_ack, vid_rvalid, cpu_rvalid, vid_rdata, sram_addr);
    end
    step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    n_checks++;
    if (cpu_rvalid !== 1'b1 || vid_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL contend_return: crv=%b vrv=%b cdata=%h required 1 0 00", cpu_rvalid, vid_rvalid, cpu_rdata);
    end
    step();
  endtask

  task automatic test_fairness();
    bit got = 1'b0;
    bit exp_c;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h0001, !got, 1'b0, 16'h8001, 8'h00);
      @(negedge clk);
`ifdef VRAM_ARB_FAIRNESS_EN
      exp_c = (i == 4);
`else
      exp_c = 1'b0;
`endif
      n_checks++;
      if (cpu_ack !== exp_c || vid_ack !== !exp_c) begin
        n_fail++;
        $display("FAIL fairness[%0d]: cpu_ack=%b vid_ack=%b required %b %b", i, cpu_ack, vid_ack, exp_c, !exp_c);
      end
      if (cpu_ack) got = 1'b1;
      step();
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (2) step();
  endtask

  task automatic test_reset_inflight();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h8001, 8'h00);
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_ack: cpu_ack=%b required 1", cpu_ack);
    end
    step();
    rst_n = 1'b0;
    drive(1'b1, 16'h0003, 1'b1, 1'b1, 16'h4444, 8'h77);
    #1;
    n_checks++;
    if (vid_ack !== 1'b0 || cpu_ack !== 1'b0 || sram_we !== 1'b0 || cpu_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_reset: vid_ack=%b cpu_ack=%b we=%b crv=%b required 0 0 0 0", vid_ack, cpu_ack, sram_we, cpu_rvalid);
    end
    repeat (2) step();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_rvalid !== 1'b0 || vid_rvalid !== 1'b0 || sram_addr !== 16'h0000) begin
        n_fail++;
        $display("FAIL inflight_after[%0d]: crv=%b vrv=%b addr=%h required 0 0 0000", i, cpu_rvalid, vid_rvalid, sram_addr);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a [4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    logic [7:0]  d [4] = '{8'h3C, 8'hC3, 8'h00, 8'h00};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(1'b0, 16'h0, 1'b1, i < 2, a[i], d[i]);
      else drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0);
      @(negedge clk);
      n_checks++;
      if (cpu_ack !== (i < 4) || sram_we !== (i < 2) || cpu_rvalid !== (i >= 3 && i <= 4)
          || (i == 3 && cpu_rdata !== 8'h3C) || (i == 4 && cpu_rdata !== 8'hC3)) begin
        n_fail++;
        $display("FAIL boundary[%0d]: ack=%b we=%b rvalid=%b data=%h required %b %b %b %h", i, cpu_ack, sram_we, cpu_rvalid, cpu_rdata,
                 i < 4, i < 2, i >= 3 && i <= 4, (i == 3) ? 8'h3C : 8'hC3);
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      smem[i] = (i < 4) ? 8'(8'h10 + i) : 8'h00;
      ref_mem[i] = (i < 4) ? 8'(8'h10 + i) : 8'h00;
    end
    test_reset();
    test_cpu_rw();
    test_video_burst();
    test_contention();
    test_fairness();
    test_reset_inflight();
    test_back_to_back();
    repeat (2) step();
    n_checks++;
    if (vq.size() != 0 || cq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: outstanding vid=%0d cpu=%0d required 0 0", vq.size(), cq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
